// File: rtl/message_printer_pkg.sv
// Shared definitions for the message printer: FSM encodings, the post-gap
// routing tag and the ASCII control bytes it emits.
package message_printer_pkg;

  localparam int MSG_ADDR_W = 4;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4,
    S_CR    = 3'd5,
    S_LF    = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  // Where the shared SEND/GAP handshake goes once its dead cycle is over.
  typedef enum logic [1:0] {
    AG_DATA = 2'd0,
    AG_LF   = 2'd1,
    AG_FIN  = 2'd2
  } after_gap_t;

endpackage

// File: rtl/message_printer.sv
// Reads MSG_LEN characters from the message RAM and hands them one at a time
// to the UART transmitter, optionally followed by CR/LF.
module message_printer
  import message_printer_pkg::*;
#(
  parameter int MSG_LEN     = 8,
  parameter int RD_LATENCY  = 1,
  parameter int APPEND_CRLF = 1,
  parameter int SKIP_NUL    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [MSG_ADDR_W-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  new_tx_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [MSG_ADDR_W-1:0] LAST_IDX  = MSG_ADDR_W'(MSG_LEN - 1);
  localparam logic [1:0]            WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t                  r_state,    w_state_nxt;
  after_gap_t              r_after,    w_after_nxt;
  logic [MSG_ADDR_W-1:0]   r_idx,      w_idx_nxt;
  logic [MSG_ADDR_W-1:0]   r_rd_addr,  w_rd_addr_nxt;
  logic [1:0]              r_wait,     w_wait_nxt;
  logic [7:0]              r_tx_data,  w_tx_data_nxt;
  logic                    r_busy,     w_busy_nxt;
  logic                    r_done,     w_done_nxt;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_after_nxt   = r_after;
    w_idx_nxt     = r_idx;
    w_rd_addr_nxt = r_rd_addr;
    w_wait_nxt    = r_wait;
    w_tx_data_nxt = r_tx_data;
    w_busy_nxt    = r_busy;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_FETCH;
          w_after_nxt   = AG_DATA;
          w_idx_nxt     = '0;
          w_rd_addr_nxt = '0;
          w_wait_nxt    = '0;
          w_busy_nxt    = 1'b1;
        end
      end
      S_FETCH: begin
        if (r_wait == WAIT_LAST) w_state_nxt = S_LOAD;
        else                     w_wait_nxt  = r_wait + 2'd1;
      end
      S_LOAD: begin
        w_tx_data_nxt = rd_data;
        // A NUL still consumes its address; it just never reaches the UART.
        if (SKIP_NUL != 0 && rd_data == ASCII_NUL) w_state_nxt = S_GAP;
        else                                       w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        case (r_after)
          AG_DATA: begin
            if (r_idx < LAST_IDX) begin
              w_idx_nxt     = r_idx + 1'b1;
              w_rd_addr_nxt = r_idx + 1'b1;
              w_wait_nxt    = '0;
              w_state_nxt   = S_FETCH;
            end else if (APPEND_CRLF != 0) begin
              w_state_nxt = S_CR;
            end else begin
              w_state_nxt = S_FIN;
            end
          end
          AG_LF:   w_state_nxt = S_LF;
          default: w_state_nxt = S_FIN;
        endcase
      end
      S_CR: begin
        w_tx_data_nxt = ASCII_CR;
        w_after_nxt   = AG_LF;
        w_state_nxt   = S_SEND;
      end
      S_LF: begin
        w_tx_data_nxt = ASCII_LF;
        w_after_nxt   = AG_FIN;
        w_state_nxt   = S_SEND;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // done and the idle values of busy/rd_addr are registered on entry to FIN.
    w_done_nxt = (w_state_nxt == S_FIN);
    if (w_state_nxt == S_FIN) begin
      w_busy_nxt    = 1'b0;
      w_rd_addr_nxt = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_after   <= AG_DATA;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_wait    <= '0;
      r_tx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_after   <= w_after_nxt;
      r_idx     <= w_idx_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_wait    <= w_wait_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // The strobe fires in the first SEND cycle with tx_busy low, so the UART
  // sees it while GAP gives its busy flag a cycle to rise.
  assign new_tx_data = (r_state == S_SEND) && !tx_busy;
  assign rd_addr     = r_rd_addr;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
